// File: rtl/morse_char_encoder.sv
// -----------------------------------------------------------------------------
// morse_char_encoder
//   Upstream feeder for the Morse serial shift-out stage. Takes one ASCII
//   character per valid/ready handshake, looks it up in an internal Morse ROM
//   and presents the 3-bit element codes one at a time on P_DATA. The shift
//   stage pulses 'next' when it has consumed the current code.
//   Element codes: dot = 3'b001, dash = 3'b111, one silent unit = 3'b000.
//
// Parameters
//   CGAP_UNITS  silence units after the last element of a character
//   WGAP_UNITS  silence units emitted for an ASCII space
//
// Ports
//   clk         in   1  clock, all state updates on the rising edge
//   rst_n       in   1  synchronous active-low reset
//   char_in     in   8  ASCII character
//   char_valid  in   1  char_in is valid
//   char_ready  out  1  encoder can accept a character (IDLE only)
//   P_DATA      out  3  current element code for the shift stage
//   next        in   1  shift stage consumed P_DATA this cycle
//   busy        out  1  encoder is not IDLE
// -----------------------------------------------------------------------------
module morse_char_encoder #(
  parameter int CGAP_UNITS = 3,
  parameter int WGAP_UNITS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic [2:0] P_DATA,
  input  logic       next,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ELEM = 3'd1,
    S_EGAP = 3'd2,
    S_CGAP = 3'd3,
    S_WGAP = 3'd4
  } state_t;

  localparam logic [2:0] CGAP_LAST = 3'(CGAP_UNITS - 1);
  localparam logic [2:0] WGAP_LAST = 3'(WGAP_UNITS - 1);

  localparam logic [2:0] CODE_DOT  = 3'b001;
  localparam logic [2:0] CODE_DASH = 3'b111;
  localparam logic [2:0] CODE_SIL  = 3'b000;

  // Morse ROM. Returns {hit, len[2:0], pat[4:0]}; pat bit i is element i
  // (1 = dash) and bit 0 is sent first. Lower-case letters fold to upper.
  function automatic logic [8:0] rom_lookup(input logic [7:0] ch);
    logic [7:0] up;
    logic [8:0] res;
    res = 9'd0;
    if ((ch >= 8'h61) && (ch <= 8'h7A)) begin
      up = ch - 8'd32;
    end else begin
      up = ch;
    end
    case (up)
      8'h41: res = {1'b1, 3'd2, 5'b00010}; // A .-
      8'h42: res = {1'b1, 3'd4, 5'b00001}; // B -...
      8'h43: res = {1'b1, 3'd4, 5'b00101}; // C -.-.
      8'h44: res = {1'b1, 3'd3, 5'b00001}; // D -..
      8'h45: res = {1'b1, 3'd1, 5'b00000}; // E .
      8'h46: res = {1'b1, 3'd4, 5'b00100}; // F ..-.
      8'h47: res = {1'b1, 3'd3, 5'b00011}; // G --.
      8'h48: res = {1'b1, 3'd4, 5'b00000}; // H ....
      8'h49: res = {1'b1, 3'd2, 5'b00000}; // I ..
      8'h4A: res = {1'b1, 3'd4, 5'b01110}; // J .---
      8'h4B: res = {1'b1, 3'd3, 5'b00101}; // K -.-
      8'h4C: res = {1'b1, 3'd4, 5'b00010}; // L .-..
      8'h4D: res = {1'b1, 3'd2, 5'b00011}; // M --
      8'h4E: res = {1'b1, 3'd2, 5'b00001}; // N -.
      8'h4F: res = {1'b1, 3'd3, 5'b00111}; // O ---
      8'h50: res = {1'b1, 3'd4, 5'b00110}; // P .--.
      8'h51: res = {1'b1, 3'd4, 5'b01011}; // Q --.-
      8'h52: res = {1'b1, 3'd3, 5'b00010}; // R .-.
      8'h53: res = {1'b1, 3'd3, 5'b00000}; // S ...
      8'h54: res = {1'b1, 3'd1, 5'b00001}; // T -
      8'h55: res = {1'b1, 3'd3, 5'b00100}; // U ..-
      8'h56: res = {1'b1, 3'd4, 5'b01000}; // V ...-
      8'h57: res = {1'b1, 3'd3, 5'b00110}; // W .--
      8'h58: res = {1'b1, 3'd4, 5'b01001}; // X -..-
      8'h59: res = {1'b1, 3'd4, 5'b01101}; // Y -.--
      8'h5A: res = {1'b1, 3'd4, 5'b00011}; // Z --..
      8'h30: res = {1'b1, 3'd5, 5'b11111}; // 0 -----
      8'h31: res = {1'b1, 3'd5, 5'b11110}; // 1 .----
      8'h32: res = {1'b1, 3'd5, 5'b11100}; // 2 ..---
      8'h33: res = {1'b1, 3'd5, 5'b11000}; // 3 ...--
      8'h34: res = {1'b1, 3'd5, 5'b10000}; // 4 ....-
      8'h35: res = {1'b1, 3'd5, 5'b00000}; // 5 .....
      8'h36: res = {1'b1, 3'd5, 5'b00001}; // 6 -....
      8'h37: res = {1'b1, 3'd5, 5'b00011}; // 7 --...
      8'h38: res = {1'b1, 3'd5, 5'b00111}; // 8 ---..
      8'h39: res = {1'b1, 3'd5, 5'b01111}; // 9 ----.
      default: res = 9'd0;
    endcase
    return res;
  endfunction

  state_t     r_state;
  logic [2:0] r_idx;
  logic [2:0] r_cnt;
  logic [2:0] r_len;
  logic [4:0] r_pat;
  logic [2:0] r_p_data;
  logic       r_ready;
  logic       r_busy;

  state_t     w_state_nxt;
  logic [2:0] w_idx_nxt;
  logic [2:0] w_cnt_nxt;
  logic [2:0] w_len_nxt;
  logic [4:0] w_pat_nxt;
  logic [2:0] w_p_data_nxt;
  logic [4:0] w_pat_shift;
  logic [8:0] w_rom;

  // Next-state, counters and the code that P_DATA will carry next cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_cnt_nxt    = r_cnt;
    w_len_nxt    = r_len;
    w_pat_nxt    = r_pat;
    w_rom        = rom_lookup(char_in);
    w_pat_shift  = 5'd0;
    w_p_data_nxt = CODE_SIL;

    case (r_state)
      // char_ready is high throughout IDLE, so char_valid alone is an accept.
      // 'next' is ignored here, including in the accept cycle.
      S_IDLE: begin
        if (char_valid) begin
          if (w_rom[8]) begin
            w_state_nxt = S_ELEM;
            w_idx_nxt   = 3'd0;
            w_len_nxt   = w_rom[7:5];
            w_pat_nxt   = w_rom[4:0];
          end else if (char_in == 8'h20) begin
            w_state_nxt = S_WGAP;
            w_cnt_nxt   = 3'd0;
          end else begin
            w_state_nxt = S_IDLE;  // unknown code: consumed, nothing sent
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ELEM: begin
        if (next) begin
          if (r_idx == (r_len - 3'd1)) begin
            w_state_nxt = S_CGAP;  // last element goes straight to char gap
            w_cnt_nxt   = 3'd0;
          end else begin
            w_state_nxt = S_EGAP;
          end
        end else begin
          w_state_nxt = S_ELEM;
        end
      end
      S_EGAP: begin
        if (next) begin
          w_state_nxt = S_ELEM;
          w_idx_nxt   = r_idx + 3'd1;
        end else begin
          w_state_nxt = S_EGAP;
        end
      end
      S_CGAP: begin
        if (next) begin
          if (r_cnt == CGAP_LAST) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 3'd1;
          end
        end else begin
          w_state_nxt = S_CGAP;
        end
      end
      S_WGAP: begin
        if (next) begin
          if (r_cnt == WGAP_LAST) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 3'd1;
          end
        end else begin
          w_state_nxt = S_WGAP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = 3'd0;
        w_cnt_nxt   = 3'd0;
      end
    endcase

    // P_DATA is registered, so derive it from the state being entered.
    w_pat_shift = w_pat_nxt >> w_idx_nxt;
    if (w_state_nxt == S_ELEM) begin
      w_p_data_nxt = w_pat_shift[0] ? CODE_DASH : CODE_DOT;
    end else begin
      w_p_data_nxt = CODE_SIL;
    end
  end

  // State, counters, latched ROM entry and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= 3'd0;
      r_cnt    <= 3'd0;
      r_len    <= 3'd0;
      r_pat    <= 5'd0;
      r_p_data <= CODE_SIL;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_cnt    <= w_cnt_nxt;
      r_len    <= w_len_nxt;
      r_pat    <= w_pat_nxt;
      r_p_data <= w_p_data_nxt;
      r_ready  <= (w_state_nxt == S_IDLE);
      r_busy   <= (w_state_nxt != S_IDLE);
    end
  end

  assign P_DATA     = r_p_data;
  assign char_ready = r_ready;
  assign busy       = r_busy;

endmodule

// File: tb/tb_morse_char_encoder.sv
// -----------------------------------------------------------------------------
// tb_morse_char_encoder
//   Self-checking bench for morse_char_encoder. A table of characters is fed
//   through the encoder; the expected code stream for each is built from a
//   dot/dash string and queued, then compared cycle by cycle against P_DATA
//   while 'next' is pulsed at a per-entry rate. Hand-written sequences cover
//   held char_valid while busy, 'next' in IDLE, and reset mid-character.
// -----------------------------------------------------------------------------
module tb_morse_char_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic [2:0] P_DATA;
  logic       next;
  logic       busy;

  always #5 clk = ~clk;

  morse_char_encoder #(.CGAP_UNITS(3), .WGAP_UNITS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .P_DATA     (P_DATA),
    .next       (next),
    .busy       (busy)
  );

  // kind: 0 = Morse character, 1 = space (word gap), 2 = ignored code
  typedef struct packed {
    logic [7:0]  ch;
    logic [39:0] morse;
    logic [1:0]  kind;
    logic [1:0]  period;
    logic        nx_acc;
  } vec_t;

  vec_t       tbl[$];
  logic [2:0] q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] c, input logic [39:0] m, input logic [1:0] k,
                     input logic [1:0] p, input logic nx);
    vec_t v;
    v.ch = c; v.morse = m; v.kind = k; v.period = p; v.nx_acc = nx;
    tbl.push_back(v);
  endtask

  // Expand a dot/dash string (right-justified, first element in the highest
  // non-zero byte) into the expected element code stream.
  task automatic push_expected(input logic [1:0] kind, input logic [39:0] m);
    logic first;
    logic [7:0] b;
    first = 1'b1;
    if (kind == 2'd0) begin
      for (int k = 4; k >= 0; k--) begin
        b = m[8*k +: 8];
        if (b != 8'h00) begin
          if (!first) q.push_back(3'b000);
          q.push_back((b == 8'h2D) ? 3'b111 : 3'b001);
          first = 1'b0;
        end
      end
      for (int k = 0; k < 3; k++) q.push_back(3'b000);
    end else if (kind == 2'd1) begin
      for (int k = 0; k < 4; k++) q.push_back(3'b000);
    end
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic accept(input logic [7:0] c, input logic nx_acc, input logic hold);
    char_in    = c;
    char_valid = 1'b1;
    next       = nx_acc;
    chk($sformatf("ready_before_accept[%c]", c), {7'd0, char_ready}, 8'd1);
    @(posedge clk);
    @(negedge clk);
    next = 1'b0;
    if (!hold) char_valid = 1'b0;
  endtask

  // Compare P_DATA against the queue head every cycle, pulsing 'next' once
  // every 'period' cycles; then confirm the encoder is back in IDLE.
  task automatic drain(input string tag, input int period);
    int cyc;
    cyc = 0;
    while ((q.size() > 0) && (cyc < 400)) begin
      chk($sformatf("pdata[%s]#%0d", tag, cyc), {5'd0, P_DATA}, {5'd0, q[0]});
      chk($sformatf("busy[%s]#%0d", tag, cyc), {7'd0, busy}, 8'd1);
      chk($sformatf("ready[%s]#%0d", tag, cyc), {7'd0, char_ready}, 8'd0);
      next = ((cyc % period) == (period - 1));
      @(posedge clk);
      if (next) void'(q.pop_front());
      cyc++;
      @(negedge clk);
      next = 1'b0;
    end
    if (q.size() > 0) begin
      chk($sformatf("drain_timeout[%s]", tag), 8'(q.size()), 8'd0);
      q.delete();
    end
    chk($sformatf("idle_pdata[%s]", tag), {5'd0, P_DATA}, 8'd0);
    chk($sformatf("idle_busy[%s]", tag), {7'd0, busy}, 8'd0);
    chk($sformatf("idle_ready[%s]", tag), {7'd0, char_ready}, 8'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    char_in    = 8'h00;
    char_valid = 1'b0;
    next       = 1'b0;

    add("E", ".",     2'd0, 2'd1, 1'b0);
    add("A", ".-",    2'd0, 2'd1, 1'b1);
    add("a", ".-",    2'd0, 2'd1, 1'b0);
    add("0", "-----", 2'd0, 2'd1, 1'b0);
    add(" ", "",      2'd1, 2'd1, 1'b1);
    add("#", "",      2'd2, 2'd1, 1'b0);
    add("Q", "--.-",  2'd0, 2'd2, 1'b0);
    add("9", "----.", 2'd0, 2'd1, 1'b0);
    add("z", "--..",  2'd0, 2'd1, 1'b0);
    add("1", ".----", 2'd0, 2'd2, 1'b0);
    add("5", ".....", 2'd0, 2'd1, 1'b0);
    add("J", ".---",  2'd0, 2'd1, 1'b0);
    add("Y", "-.--",  2'd0, 2'd3, 1'b0);
    add("B", "-...",  2'd0, 2'd1, 1'b0);
    add("@", "",      2'd2, 2'd1, 1'b0);
    add("[", "",      2'd2, 2'd1, 1'b0);
    add(8'h60, "",    2'd2, 2'd1, 1'b0);
    add("{", "",      2'd2, 2'd1, 1'b0);
    add("/", "",      2'd2, 2'd1, 1'b0);
    add(":", "",      2'd2, 2'd1, 1'b0);
    add("Z", "--..",  2'd0, 2'd1, 1'b0);

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_pdata", {5'd0, P_DATA}, 8'd0);
    chk("reset_ready", {7'd0, char_ready}, 8'd1);
    chk("reset_busy", {7'd0, busy}, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven characters.
    for (int i = 0; i < tbl.size(); i++) begin
      accept(tbl[i].ch, tbl[i].nx_acc, 1'b0);
      push_expected(tbl[i].kind, tbl[i].morse);
      drain($sformatf("%c", tbl[i].ch), int'(tbl[i].period));
    end

    // 'next' while IDLE must not change anything.
    for (int i = 0; i < 3; i++) begin
      next = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("idle_next_pdata#%0d", i), {5'd0, P_DATA}, 8'd0);
      chk($sformatf("idle_next_busy#%0d", i), {7'd0, busy}, 8'd0);
    end
    next = 1'b0;

    // 'K' with next every 3rd cycle, char_valid held high ('E') while busy.
    accept("K", 1'b0, 1'b1);
    char_in = "E";
    push_expected(2'd0, "-.-");
    drain("K_hold", 3);
    @(posedge clk);
    @(negedge clk);
    char_valid = 1'b0;
    push_expected(2'd0, ".");
    drain("E_after_K", 1);

    // Reset in the middle of the dash of 'T'.
    accept("T", 1'b0, 1'b0);
    chk("T_dash_pdata", {5'd0, P_DATA}, 8'h07);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset_pdata", {5'd0, P_DATA}, 8'd0);
    chk("midreset_ready", {7'd0, char_ready}, 8'd1);
    chk("midreset_busy", {7'd0, busy}, 8'd0);
    accept("E", 1'b0, 1'b0);
    push_expected(2'd0, ".");
    drain("E_after_reset", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
